// File: rtl/stack_unit.sv
// stack_unit: parametrised operand stack for the stack-based MIPS datapath.
// The stack sits between the ALU/memory result mux (din) and the ALU source
// muxes and data memory (tos/nos). It supports in-place DUP, SWAP, REDUCE,
// REPLACE and CLEAR. Illegal ops are blocked, latched as sticky
// overflow/underflow flags, and pulsed on fault for one cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   op       operation code, sampled every rising edge
//   din      write data for PUSH/REDUCE/REPLACE
//   clr_err  synchronous clear of the sticky error flags
//   tos/nos  top / next-on-stack values (0 when the entry does not exist)
//   count    number of valid entries, 0..DEPTH
//   empty    count==0
//   full     count==DEPTH
//   err_ovf  sticky overflow flag
//   err_unf  sticky underflow flag
//   fault    one-cycle pulse after an illegal op edge
module stack_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             err_ovf,
  output logic             err_unf,
  output logic             fault
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_DUP     = 3'd3,
    OP_SWAP    = 3'd4,
    OP_REDUCE  = 3'd5,
    OP_REPLACE = 3'd6,
    OP_CLEAR   = 3'd7
  } op_e;

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [WIDTH-1:0] mem_nxt [DEPTH];
  logic [CW-1:0]    count_q, count_nxt;
  logic             err_ovf_q, err_ovf_nxt;
  logic             err_unf_q, err_unf_nxt;
  logic             fault_q, fault_nxt;
  logic             ovf, unf;

  // Entry indices relative to the current top; only used when the guard holds.
  logic [AW-1:0] top_idx, sec_idx, new_idx;
  logic          has1, has2, not_full;

  assign top_idx  = AW'(count_q - CW'(1));
  assign sec_idx  = AW'(count_q - CW'(2));
  assign new_idx  = AW'(count_q);
  assign has1     = (count_q != '0);
  assign has2     = (count_q >= CW'(2));
  assign not_full = (count_q < CW'(DEPTH));

  // Next-state: storage, count, and error detection for the sampled op.
  always_comb begin
    mem_nxt   = mem;
    count_nxt = count_q;
    ovf       = 1'b0;
    unf       = 1'b0;
    case (op_e'(op))
      OP_NOP: ;
      OP_PUSH: begin
        if (not_full) begin
          mem_nxt[new_idx] = din;
          count_nxt        = count_q + CW'(1);
        end else begin
          ovf = 1'b1;
        end
      end
      OP_POP: begin
        if (has1) count_nxt = count_q - CW'(1);
        else      unf       = 1'b1;
      end
      OP_DUP: begin
        if (!has1) begin
          unf = 1'b1;
        end else if (!not_full) begin
          ovf = 1'b1;
        end else begin
          mem_nxt[new_idx] = mem[top_idx];
          count_nxt        = count_q + CW'(1);
        end
      end
      OP_SWAP: begin
        if (has2) begin
          mem_nxt[top_idx] = mem[sec_idx];
          mem_nxt[sec_idx] = mem[top_idx];
        end else begin
          unf = 1'b1;
        end
      end
      OP_REDUCE: begin
        if (has2) begin
          mem_nxt[sec_idx] = din;
          count_nxt        = count_q - CW'(1);
        end else begin
          unf = 1'b1;
        end
      end
      OP_REPLACE: begin
        if (has1) mem_nxt[top_idx] = din;
        else      unf              = 1'b1;
      end
      OP_CLEAR: count_nxt = '0;
      default: ;
    endcase

    // clr_err drops old flags but a same-edge new error still latches.
    fault_nxt   = ovf | unf;
    err_ovf_nxt = clr_err ? ovf : (err_ovf_q | ovf);
    err_unf_nxt = clr_err ? unf : (err_unf_q | unf);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      mem       <= mem_nxt;
      count_q   <= count_nxt;
      err_ovf_q <= err_ovf_nxt;
      err_unf_q <= err_unf_nxt;
      fault_q   <= fault_nxt;
    end
  end

  assign tos     = has1 ? mem[top_idx] : '0;
  assign nos     = has2 ? mem[sec_idx] : '0;
  assign count   = count_q;
  assign empty   = !has1;
  assign full    = !not_full;
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_stack_unit.sv
// Testbench for stack_unit (WIDTH=8, DEPTH=4): directed table, async reset
// sequence, and random ops checked against a queue-based reference model.
module tb_stack_unit;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] P_NOP = 3'd0, P_PUSH = 3'd1, P_POP = 3'd2, P_DUP = 3'd3,
                         P_SWAP = 3'd4, P_REDUCE = 3'd5, P_REPLACE = 3'd6, P_CLEAR = 3'd7;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       op = 3'd0;
  logic [WIDTH-1:0] din = '0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] tos, nos;
  logic [CW-1:0]    count;
  logic             empty, full, err_ovf, err_unf, fault;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .op(op), .din(din), .clr_err(clr_err),
    .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
    .err_ovf(err_ovf), .err_unf(err_unf), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bottom..top kept in a queue, flags as plain bits.
  logic [7:0] mq[$];
  bit m_ovf, m_unf, m_fault;

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_unf = 0; m_fault = 0;
  endtask

  task automatic model_step(input logic [2:0] o, input logic [7:0] d, input logic c);
    bit ovf = 0, unf = 0;
    int n = mq.size();
    logic [7:0] t;
    case (o)
      P_PUSH:    if (n < int'(DEPTH)) mq.push_back(d); else ovf = 1;
      P_POP:     if (n >= 1) void'(mq.pop_back()); else unf = 1;
      P_DUP:     if (n == 0) unf = 1;
                 else if (n == int'(DEPTH)) ovf = 1;
                 else mq.push_back(mq[n-1]);
      P_SWAP:    if (n >= 2) begin t = mq[n-1]; mq[n-1] = mq[n-2]; mq[n-2] = t; end
                 else unf = 1;
      P_REDUCE:  if (n >= 2) begin void'(mq.pop_back()); mq[n-2] = d; end
                 else unf = 1;
      P_REPLACE: if (n >= 1) mq[n-1] = d; else unf = 1;
      P_CLEAR:   mq.delete();
      default: ;
    endcase
    m_fault = ovf | unf;
    if (c) begin m_ovf = ovf; m_unf = unf; end
    else begin m_ovf = m_ovf | ovf; m_unf = m_unf | unf; end
  endtask

  task automatic check_model(input string tag);
    int n = mq.size();
    chk({tag, ".count"}, int'(count), n);
    chk({tag, ".tos"},   int'(tos),   (n >= 1) ? int'(mq[n-1]) : 0);
    chk({tag, ".nos"},   int'(nos),   (n >= 2) ? int'(mq[n-2]) : 0);
    chk({tag, ".empty"}, int'(empty), int'(n == 0));
    chk({tag, ".full"},  int'(full),  int'(n == int'(DEPTH)));
    chk({tag, ".ovf"},   int'(err_ovf), int'(m_ovf));
    chk({tag, ".unf"},   int'(err_unf), int'(m_unf));
    chk({tag, ".fault"}, int'(fault), int'(m_fault));
  endtask

  // Apply one op across one rising edge, leaving time at edge+1.
  task automatic do_op(input logic [2:0] o, input logic [7:0] d, input logic c);
    op = o; din = d; clr_err = c;
    @(posedge clk);
    #1;
    model_step(o, d, c);
    op = P_NOP; clr_err = 1'b0;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] din;
    logic       clr;
    int         cnt;
    logic [7:0] tos;
    logic [7:0] nos;
    bit         ovf;
    bit         unf;
    bit         flt;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{P_PUSH,    8'h11, 1'b0, 1, 8'h11, 8'h00, 0, 0, 0};
    tbl[1]  = '{P_PUSH,    8'h22, 1'b0, 2, 8'h22, 8'h11, 0, 0, 0};
    tbl[2]  = '{P_PUSH,    8'h33, 1'b0, 3, 8'h33, 8'h22, 0, 0, 0};
    tbl[3]  = '{P_SWAP,    8'h00, 1'b0, 3, 8'h22, 8'h33, 0, 0, 0};
    tbl[4]  = '{P_REDUCE,  8'h55, 1'b0, 2, 8'h55, 8'h11, 0, 0, 0};
    tbl[5]  = '{P_DUP,     8'h00, 1'b0, 3, 8'h55, 8'h55, 0, 0, 0};
    tbl[6]  = '{P_DUP,     8'h00, 1'b0, 4, 8'h55, 8'h55, 0, 0, 0};
    tbl[7]  = '{P_DUP,     8'h00, 1'b0, 4, 8'h55, 8'h55, 1, 0, 1};
    tbl[8]  = '{P_NOP,     8'h00, 1'b0, 4, 8'h55, 8'h55, 1, 0, 0};
    tbl[9]  = '{P_CLEAR,   8'h00, 1'b0, 0, 8'h00, 8'h00, 1, 0, 0};
    tbl[10] = '{P_POP,     8'h00, 1'b0, 0, 8'h00, 8'h00, 1, 1, 1};
    tbl[11] = '{P_REPLACE, 8'h77, 1'b0, 0, 8'h00, 8'h00, 1, 1, 1};
    tbl[12] = '{P_POP,     8'h00, 1'b1, 0, 8'h00, 8'h00, 0, 1, 1};
    tbl[13] = '{P_NOP,     8'h00, 1'b1, 0, 8'h00, 8'h00, 0, 0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", int'(count), 0);
    chk("rst.empty", int'(empty), 1);
    chk("rst.full",  int'(full), 0);
    chk("rst.tos",   int'(tos), 0);
    chk("rst.nos",   int'(nos), 0);
    chk("rst.flags", int'({err_ovf, err_unf, fault}), 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed table from the operation scenarios.
    for (int i = 0; i < 14; i++) begin
      do_op(tbl[i].op, tbl[i].din, tbl[i].clr);
      chk($sformatf("tbl%0d.count", i), int'(count), tbl[i].cnt);
      chk($sformatf("tbl%0d.tos", i),   int'(tos),   int'(tbl[i].tos));
      chk($sformatf("tbl%0d.nos", i),   int'(nos),   int'(tbl[i].nos));
      chk($sformatf("tbl%0d.empty", i), int'(empty), int'(tbl[i].cnt == 0));
      chk($sformatf("tbl%0d.full", i),  int'(full),  int'(tbl[i].cnt == int'(DEPTH)));
      chk($sformatf("tbl%0d.ovf", i),   int'(err_ovf), int'(tbl[i].ovf));
      chk($sformatf("tbl%0d.unf", i),   int'(err_unf), int'(tbl[i].unf));
      chk($sformatf("tbl%0d.fault", i), int'(fault), int'(tbl[i].flt));
    end

    // Async reset mid-cycle with a PUSH pending.
    do_op(P_PUSH, 8'hAA, 1'b0);
    do_op(P_PUSH, 8'hBB, 1'b0);
    check_model("pre_rst");
    op = P_PUSH; din = 8'hDD;
    #2;
    rst = 1'b0;
    #1;
    chk("arst.count", int'(count), 0);
    chk("arst.empty", int'(empty), 1);
    chk("arst.tos",   int'(tos), 0);
    chk("arst.nos",   int'(nos), 0);
    chk("arst.flags", int'({err_ovf, err_unf, fault}), 0);
    @(posedge clk);
    #1;
    chk("arst_edge.count", int'(count), 0);
    op = P_NOP;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    do_op(P_PUSH, 8'hCC, 1'b0);
    chk("post_rst.count", int'(count), 1);
    chk("post_rst.tos",   int'(tos), 8'hCC);
    check_model("post_rst");

    // Random ops against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] ro;
      logic [7:0] rd;
      logic       rc;
      ro = 3'($urandom_range(0, 7));
      rd = 8'($urandom);
      rc = ($urandom_range(0, 7) == 0);
      do_op(ro, rd, rc);
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

Parametrised operand stack for the stack-based MIPS datapath, replacing the fixed push/pop/tos stack. It adds configurable width and depth, an occupancy count, full/empty status, next-on-stack visibility, and in-place DUP/SWAP/REDUCE/REPLACE/CLEAR operations. Overflow and underflow are detected, blocked and latched. It sits between the ALU/memory result mux (din) and the ALU source muxes and data memory (tos/nos).

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 16, number of stack entries (>=2)
- CW, $clog2(DEPTH+1), width of count (derived, not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- op  in  3  operation code, sampled every rising edge
- din  in  WIDTH  write data for PUSH/REDUCE/REPLACE
- clr_err  in  1  synchronous clear of sticky error flags
- tos  out  WIDTH  top-of-stack value
- nos  out  WIDTH  next-on-stack value
- count  out  CW  number of valid entries, 0..DEPTH
- empty  out  1  count==0
- full  out  1  count==DEPTH
- err_ovf  out  1  sticky overflow flag
- err_unf  out  1  sticky underflow flag
- fault  out  1  one-cycle pulse: the op sampled on the previous edge was illegal

## Operation
- Storage is DEPTH registers mem[0..DEPTH-1]. mem[0] is the bottom entry, and mem[count-1] is the top.
- tos = mem[count-1] if count>=1, else 0. nos = mem[count-2] if count>=2, else 0. Both are combinational from registers.
- The legality condition for each op is given in brackets. All writes use pre-edge values.
  - 000 NOP [always]: no change.
  - 001 PUSH [count<DEPTH]: mem[count]<=din, count+1.
  - 010 POP [count>=1]: count-1. Entry contents are not cleared.
  - 011 DUP [1<=count<DEPTH]: mem[count]<=tos, count+1.
  - 100 SWAP [count>=2]: exchange mem[count-1] and mem[count-2].
  - 101 REDUCE [count>=2]: mem[count-2]<=din, count-1. This is the binary ALU result replacing both operands.
  - 110 REPLACE [count>=1]: mem[count-1]<=din.
  - 111 CLEAR [always]: count<=0.
- Illegal op handling:
  - No storage or count change.
  - fault=1 for the following cycle.
  - An op that would exceed DEPTH (PUSH, DUP) sets err_ovf.
  - An op that needs more entries than present (POP, SWAP, REDUCE, REPLACE, DUP with count==0) sets err_unf.
- Sticky flags hold until a clr_err edge. If clr_err and a new illegal op occur on the same edge, the new error's flag is set; the other flag clears.
- CLEAR never faults and does not touch the error flags.

## Timing
- All state changes happen on the rising clk edge. Outputs reflect the new state immediately after that edge, so results are visible with 1-cycle latency.
- Back-to-back ops are allowed every cycle with no stall or handshake. Each op sees the state left by the previous edge.
- fault is registered: it is high exactly the one cycle after the illegal op's edge.
- Reset (rst=0, asynchronous):
  - count=0, empty=1, full=0, tos=0, nos=0.
  - err_ovf=0, err_unf=0, fault=0.
  - mem contents are not required to be reset.
- Reset asserted mid-sequence aborts any op in that cycle. The first edge after rst rises executes normally.
- count arithmetic is CW bits wide, and legality checks prevent wrap-around. count never exceeds DEPTH or goes below 0.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
- Reset, then PUSH 0x11, 0x22, 0x33 -> count=3, tos=0x33, nos=0x22, empty=0, full=0, no fault.
- From {0x11,0x22,0x33}: SWAP -> tos=0x22, nos=0x33. Then REDUCE din=0x55 -> count=2, tos=0x55, nos=0x11.
- From {0x11,0x55}: DUP, DUP -> the first DUP gives count=3, tos=0x55. The second DUP gives count=4, full=1. A third DUP gives fault=1 for one cycle, err_ovf=1, count stays 4, tos=0x55.
- CLEAR, then POP -> count=0, fault pulse, err_unf=1. REPLACE din=0x77 -> still empty, err_unf stays 1, tos=0.
- Set both flags, then assert clr_err together with an illegal POP on an empty stack -> err_unf=1, err_ovf=0. clr_err alone on the next edge -> both flags 0.
- PUSH 0xAA and 0xBB, assert rst low asynchronously mid-cycle with op=PUSH -> outputs go to their reset values before the next edge. After release, PUSH 0xCC -> count=1, tos=0xCC.
